fp_rsp_arb: RTL and testbench

- Collects completed results from NUM_INPUTS fixed-latency FP cores (sqrt, div, fma, cvt…) into one writeback stream toward the FPU commit stage.
- It is the consumer side of each core's valid_out/ready_out/tag_out handshake.
- Round-robin arbitration, a 2-entry registered output FIFO, and per-result fflags merge.
- ready_in never depends combinationally on ready_out, so core stall chains stay short.

---
 rtl/fp_rsp_arb_pkg.sv | 19 +
 rtl/fp_rsp_arb_rr_arbiter.sv | 44 ++++
 rtl/fp_rsp_arb.sv | 141 ++++++++++++++
 tb/tb_fp_rsp_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_rsp_arb_pkg.sv
// rtl/fp_rsp_arb_pkg.sv - shared FP response types: IEEE flag struct and flag merge helper
package fp_rsp_arb_pkg;

    localparam int WORD_W = 32;
    localparam int FLAG_W = 5;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    function automatic fflags_t fflags_or(input fflags_t a, input fflags_t b);
        return a | b;
    endfunction

endpackage

// File: rtl/fp_rsp_arb_rr_arbiter.sv
// rtl/fp_rsp_arb_rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module fp_rsp_arb_rr_arbiter #(
    parameter int NUM_INPUTS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS-1:0]           req,
    input  logic                            advance,
    output logic [NUM_INPUTS-1:0]           grant,
    output logic [$clog2(NUM_INPUTS)-1:0]   grant_idx
);

    localparam int PW = $clog2(NUM_INPUTS);

    logic [PW-1:0] rr_ptr;
    logic [PW:0]   cand;

    // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_INPUTS)) begin
                cand = cand - (PW+1)'(NUM_INPUTS);
            end
            if (req[cand[PW-1:0]]) begin
                grant                = '0;
                grant[cand[PW-1:0]]  = 1'b1;
                grant_idx            = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == PW'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fp_rsp_arb.sv
// rtl/fp_rsp_arb.sv - FP core response arbiter with 2-entry writeback FIFO; FP_RSP_PERF_EN adds perf counters
module fp_rsp_arb
    import fp_rsp_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int LANES      = 1,
    parameter int TAGW       = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_INPUTS-1:0]                valid_in,
    output logic [NUM_INPUTS-1:0]                ready_in,
    input  logic [NUM_INPUTS*TAGW-1:0]           tag_in,
    input  logic [NUM_INPUTS*LANES*WORD_W-1:0]   data_in,
    input  logic [NUM_INPUTS-1:0]                has_fflags_in,
    input  logic [NUM_INPUTS*LANES*FLAG_W-1:0]   fflags_in,
    output logic                                 valid_out,
    input  logic                                 ready_out,
    output logic [TAGW-1:0]                      tag_out,
    output logic [LANES*WORD_W-1:0]              data_out,
    output logic                                 has_fflags_out,
    output logic [LANES*FLAG_W-1:0]              fflags_out,
    output logic [FLAG_W-1:0]                    fflags_merged
`ifdef FP_RSP_PERF_EN
    ,
    output logic [31:0]                          perf_stall_cycles,
    output logic [31:0]                          perf_conflicts
`endif
);

    localparam int PW = $clog2(NUM_INPUTS);

    typedef struct packed {
        logic [TAGW-1:0]           tag;
        logic [LANES*WORD_W-1:0]   data;
        logic                      has_fflags;
        logic [LANES*FLAG_W-1:0]   fflags;
    } rsp_t;

    rsp_t                   mem [2];
    rsp_t                   head;
    rsp_t                   push_rsp;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic [NUM_INPUTS-1:0]  grant;
    logic [PW-1:0]          grant_idx;
    logic                   has_room;
    logic                   push;
    logic                   pop;
    fflags_t                merged;

    // Room is judged from the registered count only, keeping ready_out off the ready_in path.
    assign has_room  = (count != 2'd2);
    assign ready_in  = (reset && has_room) ? grant : '0;
    assign push      = |(valid_in & ready_in);
    assign valid_out = (count != 2'd0);
    assign pop       = valid_out && ready_out;

    fp_rsp_arb_rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset      (reset),
        .req        (valid_in),
        .advance    (push),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        push_rsp = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == PW'(i)) begin
                push_rsp.tag        = tag_in[i*TAGW +: TAGW];
                push_rsp.data       = data_in[i*LANES*WORD_W +: LANES*WORD_W];
                push_rsp.has_fflags = has_fflags_in[i];
                push_rsp.fflags     = fflags_in[i*LANES*FLAG_W +: LANES*FLAG_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_rsp;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head           = mem[rd_ptr];
    assign tag_out        = head.tag;
    assign data_out       = head.data;
    assign has_fflags_out = head.has_fflags;
    assign fflags_out     = head.fflags;

    always_comb begin
        merged = '0;
        for (int l = 0; l < LANES; l++) begin
            merged = fflags_or(merged, head.fflags[l*FLAG_W +: FLAG_W]);
        end
        if (!head.has_fflags) begin
            merged = '0;
        end
    end

    assign fflags_merged = merged;

`ifdef FP_RSP_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_conflicts    <= '0;
        end else begin
            if (valid_out && !ready_out) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            // More than one bit set: clearing the lowest set bit leaves something.
            if (((valid_in & (valid_in - 1'b1)) != '0) && has_room) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_rsp_arb.sv
// tb/tb_fp_rsp_arb.sv - randomized self-checking bench for fp_rsp_arb against a queue model
module tb_fp_rsp_arb;

    localparam int N  = 4;
    localparam int L  = 2;
    localparam int T  = 4;
    localparam int DW = L * 32;
    localparam int FW = L * 5;

    logic            clk;
    logic            reset;
    logic [N-1:0]    valid_in;
    logic [N-1:0]    ready_in;
    logic [N*T-1:0]  tag_in;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    has_fflags_in;
    logic [N*FW-1:0] fflags_in;
    logic            valid_out;
    logic            ready_out;
    logic [T-1:0]    tag_out;
    logic [DW-1:0]   data_out;
    logic            has_fflags_out;
    logic [FW-1:0]   fflags_out;
    logic [4:0]      fflags_merged;
`ifdef FP_RSP_PERF_EN
    logic [31:0]     perf_stall_cycles;
    logic [31:0]     perf_conflicts;
`endif

    fp_rsp_arb #(.NUM_INPUTS(N), .LANES(L), .TAGW(T)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .tag_in         (tag_in),
        .data_in        (data_in),
        .has_fflags_in  (has_fflags_in),
        .fflags_in      (fflags_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .tag_out        (tag_out),
        .data_out       (data_out),
        .has_fflags_out (has_fflags_out),
        .fflags_out     (fflags_out),
        .fflags_merged  (fflags_merged)
`ifdef FP_RSP_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_conflicts    (perf_conflicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [T-1:0]  tag;
        logic [DW-1:0] data;
        logic          has;
        logic [FW-1:0] fl;
    } ent_t;

    ent_t          q[$];
    int            rr;
    logic [N-1:0]  pv;
    logic [N-1:0]  acc_prev;
    logic [T-1:0]  ptag  [N];
    logic [DW-1:0] pdata [N];
    logic          phas  [N];
    logic [FW-1:0] pfl   [N];
    logic [31:0]   exp_stall;
    logic [31:0]   exp_conf;

    logic [N-1:0]  allow;
    int            vpct;
    int            rpct;
    bit            tag_idx;
    bit            fl_force;
    bit            fl_has;

    logic [N-1:0]  snap_ready;
    logic          snap_valid;
    logic [T-1:0]  snap_tag;
    logic [4:0]    snap_merged;
    int            acc_log[$];
    int            out_log[$];

    int vectors;
    int miscompares;

    for (genvar gi = 0; gi < N; gi++) begin : g_contract
        a_hold: assert property (@(posedge clk) disable iff (!reset)
            valid_in[gi] && !ready_in[gi] |=> valid_in[gi]
                && $stable(tag_in[gi*T +: T]) && $stable(data_in[gi*DW +: DW])
                && $stable(has_fflags_in[gi]) && $stable(fflags_in[gi*FW +: FW]))
            else $error("FAIL input_hold core %0d: valid=%b payload changed while stalled, required stable", gi, valid_in[gi]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            valid_in[i]              = pv[i];
            tag_in[i*T +: T]         = ptag[i];
            data_in[i*DW +: DW]      = pdata[i];
            has_fflags_in[i]         = phas[i];
            fflags_in[i*FW +: FW]    = pfl[i];
        end
    endtask

    task automatic step();
        int           g;
        int           j;
        logic [N-1:0] er;
        logic [4:0]   em;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!(pv[i] && !acc_prev[i])) begin
                pv[i]    = allow[i] && ($urandom_range(99) < vpct);
                ptag[i]  = tag_idx ? T'(i) : T'($urandom);
                pdata[i] = {$urandom, $urandom};
                phas[i]  = 1'($urandom);
                pfl[i]   = FW'($urandom);
                if (fl_force && i == 2) begin
                    phas[i] = fl_has;
                    pfl[i]  = 10'b00101_00001;
                end
            end
        end
        drive();
        ready_out = ($urandom_range(99) < rpct);
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (rr + k) % N;
            if (g < 0 && pv[j]) g = j;
        end
        er = (g >= 0 && q.size() < 2) ? N'(1 << g) : '0;
        chk("ready_in", ready_in, er);
        chk("valid_out", valid_out, q.size() != 0);
        if (q.size() != 0) begin
            em = q[0].has ? (q[0].fl[4:0] | q[0].fl[9:5]) : 5'd0;
            chk("tag_out", tag_out, q[0].tag);
            chk("data_out", data_out, q[0].data);
            chk("has_fflags_out", has_fflags_out, q[0].has);
            chk("fflags_out", fflags_out, q[0].fl);
            chk("fflags_merged", fflags_merged, em);
        end
`ifdef FP_RSP_PERF_EN
        chk("perf_stall_cycles", perf_stall_cycles, exp_stall);
        chk("perf_conflicts", perf_conflicts, exp_conf);
`endif
        snap_ready  = ready_in;
        snap_valid  = valid_out;
        snap_tag    = tag_out;
        snap_merged = fflags_merged;
        for (int i = 0; i < N; i++) if (valid_in[i] && ready_in[i]) acc_log.push_back(i);
        if (valid_out && ready_out) out_log.push_back(int'(tag_out));
        @(posedge clk);
        if (q.size() != 0 && !ready_out) exp_stall++;
        if ($countones(pv) >= 2 && q.size() < 2) exp_conf++;
        if (q.size() != 0 && ready_out) void'(q.pop_front());
        if (er != '0) begin
            q.push_back('{tag: ptag[g], data: pdata[g], has: phas[g], fl: pfl[g]});
            rr = (g + 1) % N;
        end
        acc_prev = er;
    endtask

    task automatic do_reset(input bit all_valid);
        #3;
        reset = 1'b0;
        #1;
        chk("async_valid_out_drop", valid_out, 1'b0);
        q.delete();
        rr        = 0;
        acc_prev  = '0;
        exp_stall = '0;
        exp_conf  = '0;
        for (int i = 0; i < N; i++) begin
            pv[i]    = all_valid;
            ptag[i]  = T'(i);
            pdata[i] = {$urandom, $urandom};
            phas[i]  = 1'b0;
            pfl[i]   = '0;
        end
        drive();
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_ready_in", ready_in, '0);
            chk("rst_valid_out", valid_out, 1'b0);
            chk("rst_tag_out", tag_out, '0);
            chk("rst_data_out", data_out, '0);
            chk("rst_fflags_out", fflags_out, '0);
`ifdef FP_RSP_PERF_EN
            chk("rst_perf_stall", perf_stall_cycles, 32'd0);
            chk("rst_perf_conf", perf_conflicts, 32'd0);
`endif
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0; ready_out = 1'b0;
        valid_in = '0; tag_in = '0; data_in = '0; has_fflags_in = '0; fflags_in = '0;
        pv = '0; acc_prev = '0; rr = 0;
        allow = '1; vpct = 100; rpct = 100; tag_idx = 1'b1; fl_force = 1'b0; fl_has = 1'b0;

        // reset with every core requesting, then fairness with continuous traffic
        do_reset(1'b1);
        out_log.delete();
        step();
        chk("first_grant", snap_ready, 4'b0001);
        step();
        chk("first_valid", snap_valid, 1'b1);
        chk("first_tag", snap_tag, 4'd0);
        repeat (10) step();
        chk("fair_count", out_log.size(), 11);
        for (int k = 0; k < 11; k++) begin
            chk("fair_tag", (k < out_log.size()) ? out_log[k] : -1, k % 4);
        end

        // backpressure: inputs 1 and 2 only, writeback stalled
        do_reset(1'b0);
        allow = 4'b0110; rpct = 0;
        acc_log.delete();
        repeat (5) step();
        chk("bp_accepts", acc_log.size(), 2);
        chk("bp_first", (acc_log.size() > 0) ? acc_log[0] : -1, 1);
        chk("bp_second", (acc_log.size() > 1) ? acc_log[1] : -1, 2);
        chk("bp_full_ready", snap_ready, 4'b0000);
        allow = 4'b0000; rpct = 100;
        out_log.delete();
        repeat (2) step();
        chk("bp_drain0", (out_log.size() > 0) ? out_log[0] : -1, 1);
        chk("bp_drain1", (out_log.size() > 1) ? out_log[1] : -1, 2);

        // sparse requests across the wrap point
        do_reset(1'b0);
        allow = 4'b1000; rpct = 100;
        out_log.delete();
        step();
        chk("sparse_grant3", snap_ready, 4'b1000);
        allow = 4'b0001;
        step();
        chk("sparse_grant0", snap_ready, 4'b0001);
        step();
        chk("sparse_out0", (out_log.size() > 0) ? out_log[0] : -1, 3);
        chk("sparse_out1", (out_log.size() > 1) ? out_log[1] : -1, 0);

        // flag merge with and without has_fflags
        do_reset(1'b0);
        allow = 4'b0100; rpct = 0; fl_force = 1'b1; fl_has = 1'b1;
        repeat (2) step();
        chk("flags_merged_on", snap_merged, 5'b00101);
        do_reset(1'b0);
        fl_has = 1'b0;
        repeat (2) step();
        chk("flags_merged_off", snap_merged, 5'b00000);
        fl_force = 1'b0;

        // fill to full, then reset mid-cycle; nothing stale may reappear
        do_reset(1'b0);
        allow = 4'b1111; vpct = 100; rpct = 0;
        repeat (3) step();
        chk("full_valid", snap_valid, 1'b1);
        chk("full_ready", snap_ready, 4'b0000);
        do_reset(1'b0);
        vpct = 0;
        step();
        chk("post_reset_empty", snap_valid, 1'b0);

        // randomized traffic
        tag_idx = 1'b0; allow = '1;
        vpct = 60; rpct = 70;
        repeat (300) step();
        vpct = 90; rpct = 30;
        repeat (300) step();
        vpct = 30; rpct = 90;
        repeat (200) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
